// File: rtl/cache_refill_axi.sv
// Cache-miss service engine: optional AXI write burst of the dirty victim line,
// then an AXI read burst of the missing line, finished by a one-cycle refresh pulse.
module cache_refill_axi #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss,
  input  logic                     write_back,
  input  logic [31:0]              axi_raddr,
  input  logic [31:0]              axi_waddr,
  input  logic [LINE_WORDS*32-1:0] wb_line,
  output logic                     refresh,
  output logic [LINE_WORDS*32-1:0] refill_line,
  output logic                     stallreq,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LINE_W = LINE_WORDS * 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [BEAT_W-1:0]   beat, beat_d;
  logic                latch;
  logic [LINE_W-1:0]   line_q, line_d;

  assign awlen    = 8'(LINE_WORDS - 1);
  assign arlen    = 8'(LINE_WORDS - 1);
  assign awsize   = 3'b010;
  assign arsize   = 3'b010;
  assign awburst  = 2'b01;
  assign arburst  = 2'b01;
  assign wstrb    = 4'hF;
  assign stallreq = miss | (state != IDLE);

  // Next-state and beat sequencing
  always_comb begin
    state_d = state;
    beat_d  = beat;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        beat_d = '0;
        if (miss) begin
          latch   = 1'b1;
          state_d = write_back ? AW : AR;
        end
      end
      AW: if (awvalid && awready) state_d = W;
      W: begin
        if (wvalid && wready) begin
          beat_d = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state_d = B;
            beat_d  = '0;
          end
        end
      end
      B:  if (bready && bvalid) state_d = AR;
      AR: if (arvalid && arready) state_d = R;
      R: begin
        if (rready && rvalid) begin
          beat_d = beat + 1'b1;
          if (rlast) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign line_d = latch ? wb_line : line_q;

  // Bus outputs are registered from the next state so they change only on the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      line_q      <= '0;
      awaddr      <= '0;
      araddr      <= '0;
      wdata       <= '0;
      refill_line <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      wlast       <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      refresh     <= 1'b0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      if (latch) begin
        awaddr <= axi_waddr;
        araddr <= axi_raddr;
        line_q <= wb_line;
      end
      if (rready && rvalid) refill_line[{beat, 5'd0} +: 32] <= rdata;
      wdata   <= line_d[{beat_d, 5'd0} +: 32];
      awvalid <= (state_d == AW);
      wvalid  <= (state_d == W);
      wlast   <= (state_d == W) && (beat_d == LAST_BEAT);
      bready  <= (state_d == B);
      arvalid <= (state_d == AR);
      rready  <= (state_d == R);
      refresh <= (state_d == DONE);
    end
  end

endmodule

// File: doc/cache_refill_axi.md
# cache_refill_axi

Cache-miss service engine that sits between the two-way cache tag/data arrays and the AXI bus. It watches the tag block's `miss`/`write_back` outputs. When a victim must be evicted, it writes the 8-word line to memory with an AXI write burst. It then fetches the missing line with an AXI read burst and returns it with a one-cycle `refresh` pulse, which updates the tag and data arrays and LRU state.

## Interface
Parameters:
- `LINE_WORDS`, 8: 32-bit words per cache line; also the burst length. `awlen`/`arlen` = `LINE_WORDS-1`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `miss` in 1: tag block reports a cached miss.
- `write_back` in 1: the LRU victim is valid and must be written back first.
- `axi_raddr` in 32: line-aligned refill address.
- `axi_waddr` in 32: line-aligned victim address.
- `wb_line` in 256: victim line data from the data array.
- `refresh` out 1: one-cycle pulse when the refill line is complete.
- `refill_line` out 256: refill data. Beat k maps to bits [32k+31:32k].
- `stallreq` out 1: `miss | (state != IDLE)`.
- `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bvalid` in 1, `bready` out 1.
- `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1.
- `rdata` in 32, `rlast` in 1, `rvalid` in 1, `rready` out 1.

## Operation
- Constant outputs:
  - `awlen` = `arlen` = 7, `awsize` = `arsize` = 3'b010, `awburst` = `arburst` = 2'b01 (INCR).
  - `wstrb` = 4'hF.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - On `miss`, latch `axi_raddr`, `axi_waddr` and `wb_line` into internal registers.
  - Clear the 3-bit beat counter.
  - Go to AW if `write_back`, otherwise go to AR.
- AW: `awvalid`=1 with the latched waddr. On `awready`, go to W.
- W:
  - `wvalid`=1 and `wdata` = latched word[beat].
  - `wlast` = (beat == 7).
  - On `wvalid & wready`, beat increments. The handshake on beat 7 goes to B and clears beat.
- B: `bready`=1. On `bvalid`, go to AR. The response code is ignored.
- AR: `arvalid`=1 with the latched raddr. On `arready`, go to R.
- R:
  - `rready`=1.
  - On `rvalid`, write `rdata` into `refill_line` word[beat] and increment beat (3-bit, wraps).
  - `rvalid & rlast` goes to DONE.
  - An early `rlast` leaves the unreceived words holding their previous value.
  - More than 8 beats wrap and overwrite from word 0.
- DONE: `refresh`=1 for exactly this cycle, then go to IDLE.
  - The tag array updates on this edge, so `miss` seen in the following IDLE cycle reflects the new tag.
- `miss` is ignored outside IDLE. Input changes after latching do not affect the transaction.
- Each valid holds until its handshake. Addresses and data are stable while valid.
- AW completes before W starts. The read starts only after B completes.

## Timing
- Reset values: all valids, `bready`, `rready`, `wlast` and `refresh` = 0; `refill_line` = 0; state = IDLE; beat = 0.
- `awaddr`/`araddr`/`wdata` = 0 after reset until the first latch.
- Reset mid-transaction returns to IDLE in the next cycle with all valids low and no `refresh`. Outstanding bus beats are abandoned.
- Latency with a zero-wait slave (ready/valid always asserted), miss seen at cycle t0:
  - Clean miss: `arvalid` at t0+1, R beats at t0+2..t0+9, `refresh` at t0+10.
  - Dirty miss: `awvalid` at t0+1, W beats at t0+2..t0+9, B at t0+10, AR at t0+11, R beats at t0+12..t0+19, `refresh` at t0+20.
- Each slave stall cycle adds exactly one cycle.
- `stallreq` is combinational; it is high in the same cycle `miss` rises and stays high through DONE.

## Test plan
- Clean miss, `axi_raddr`=0x1FC0_0100, slave returns words 0x11..0x88, zero wait:
  - `araddr`=0x1FC0_0100, `arlen`=7, no AW activity.
  - `refresh` at t0+10 with `refill_line`=0x88..11 (word k=0x11*(k+1)).
  - Back in IDLE at t0+11.
- Dirty miss, `axi_waddr`=0x0000_2A00, `wb_line` word k = k:
  - `awaddr`=0x0000_2A00 and `wdata` 0..7; `wlast` only on the eighth beat.
  - AR issued only after `bvalid`; `refresh` at t0+20.
- Backpressure: `awready`/`wready`/`arready` delayed 3 cycles each and `rvalid` gapped every other cycle.
  - Valids and data held stable through every stall; the line is assembled correctly; `refresh` is a single pulse.
- `miss` toggling and `axi_raddr` changing mid-refill:
  - Ignored; the latched address is used.
  - A new miss is accepted only in IDLE after DONE.
- Early `rlast` on beat 4:
  - DONE follows; words 5..7 keep their prior values; exactly one `refresh`.
- `rst` asserted during the W beat 3 stall:
  - Next cycle all valids are 0 and state is IDLE.
  - The following clean miss completes normally with `refresh` at t0+10.
